div_unit: RTL and testbench

Iterative radix-2 divider implementing the RV32M DIV, DIVU, REM and REMU instructions, which are left out of the single-cycle ALU. It sits in the execute stage beside the ALU and takes the same in1/in2 operands from the operand-select mux. Its result joins the execute result mux downstream of the ALU. The pipeline stalls on `busy` and captures `out` on the `done` pulse.

---
 rtl/rv32ima_pkg.sv | 22 ++
 rtl/div_unit.sv | 167 ++++++++++++++++
 tb/tb_div_unit.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv32ima_pkg.sv
// Shared RV32IMA definitions: datapath width plus the divider op and state encodings.
package rv32ima_pkg;

  localparam int BIT_WIDTH = 32;
  localparam int DIV_STEPS = BIT_WIDTH;
  localparam int DIV_CNT_W = $clog2(BIT_WIDTH);

  typedef enum logic [1:0] {
    DIV_DIV  = 2'd0,
    DIV_DIVU = 2'd1,
    DIV_REM  = 2'd2,
    DIV_REMU = 2'd3
  } div_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

endpackage

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Signed ops divide magnitudes and fix the signs up afterwards.
module div_unit
  import rv32ima_pkg::*;
(
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 start,
  input  div_op_t              div_op,
  input  logic [BIT_WIDTH-1:0] in1,
  input  logic [BIT_WIDTH-1:0] in2,
  input  logic                 flush,
  output logic                 busy,
  output logic                 done,
  output logic [BIT_WIDTH-1:0] out
);

  localparam logic [BIT_WIDTH-1:0] MIN_NEG = {1'b1, {(BIT_WIDTH-1){1'b0}}};

  div_state_t             r_state;
  div_state_t             w_nextState;
  div_op_t                r_op;
  logic                   r_signedOp;
  logic                   r_qNeg;
  logic                   r_rNeg;
  logic                   r_fixed;
  logic [BIT_WIDTH-1:0]   r_rem;
  logic [BIT_WIDTH-1:0]   r_quo;
  logic [BIT_WIDTH-1:0]   r_divisor;
  logic [BIT_WIDTH-1:0]   r_result;
  logic [BIT_WIDTH-1:0]   r_out;
  logic [DIV_CNT_W-1:0]   r_count;

  logic                   w_isSigned;
  logic                   w_isRem;
  logic                   w_divByZero;
  logic                   w_overflow;
  logic                   w_special;
  logic                   w_accept;
  logic [BIT_WIDTH-1:0]   w_specialResult;
  logic [BIT_WIDTH-1:0]   w_abs1;
  logic [BIT_WIDTH-1:0]   w_abs2;
  logic [BIT_WIDTH:0]     w_trial;
  logic                   w_trialOk;
  logic [BIT_WIDTH-1:0]   w_quoFinal;
  logic [BIT_WIDTH-1:0]   w_remFinal;
  logic [BIT_WIDTH-1:0]   w_result;

  assign w_isSigned  = (div_op == DIV_DIV) || (div_op == DIV_REM);
  assign w_isRem     = (div_op == DIV_REM) || (div_op == DIV_REMU);
  assign w_divByZero = (in2 == '0);
  assign w_overflow  = w_isSigned && (in1 == MIN_NEG) && (in2 == '1);
  assign w_special   = w_divByZero || w_overflow;
  assign w_accept    = (r_state == IDLE) && start && !flush;

  // Overflow quotient is the dividend itself (0x80000000), remainder zero.
  assign w_specialResult = w_divByZero ? (w_isRem ? in1 : '1)
                                       : (w_isRem ? '0 : in1);

  assign w_abs1 = (w_isSigned && in1[BIT_WIDTH-1]) ? -in1 : in1;
  assign w_abs2 = (w_isSigned && in2[BIT_WIDTH-1]) ? -in2 : in2;

  assign w_trial   = {r_rem, r_quo[BIT_WIDTH-1]} - {1'b0, r_divisor};
  assign w_trialOk = ~w_trial[BIT_WIDTH];

  assign w_quoFinal = (r_signedOp && r_qNeg) ? -r_quo : r_quo;
  assign w_remFinal = (r_signedOp && r_rNeg) ? -r_rem : r_rem;
  assign w_result   = ((r_op == DIV_REM) || (r_op == DIV_REMU)) ? w_remFinal : w_quoFinal;

  assign out = r_out;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_nextState = w_special ? DONE : CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (r_count == DIV_CNT_W'(DIV_STEPS - 1)) begin
          w_nextState = FIX;
        end
      end
      FIX: begin
        busy = 1'b1;
        if (r_fixed) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        done        = 1'b1;
        w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
    if (flush) begin
      w_nextState = IDLE;
    end
  end

  // FIX spends one cycle registering the sign-corrected result before it
  // reaches out, keeping the negate adders off the out load path.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_op       <= DIV_DIV;
      r_signedOp <= 1'b0;
      r_qNeg     <= 1'b0;
      r_rNeg     <= 1'b0;
      r_fixed    <= 1'b0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_divisor  <= '0;
      r_result   <= '0;
      r_out      <= '0;
      r_count    <= '0;
    end else if (flush) begin
      r_fixed <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op       <= div_op;
            r_signedOp <= w_isSigned;
            r_qNeg     <= w_isSigned && (in1[BIT_WIDTH-1] ^ in2[BIT_WIDTH-1]);
            r_rNeg     <= w_isSigned && in1[BIT_WIDTH-1];
            r_divisor  <= w_abs2;
            r_quo      <= w_abs1;
            r_rem      <= '0;
            r_count    <= '0;
            r_fixed    <= 1'b0;
            if (w_special) begin
              r_out <= w_specialResult;
            end
          end
        end
        CALC: begin
          r_rem   <= w_trialOk ? w_trial[BIT_WIDTH-1:0] : {r_rem[BIT_WIDTH-2:0], r_quo[BIT_WIDTH-1]};
          r_quo   <= {r_quo[BIT_WIDTH-2:0], w_trialOk};
          r_count <= r_count + DIV_CNT_W'(1);
        end
        FIX: begin
          if (!r_fixed) begin
            r_result <= w_result;
            r_fixed  <= 1'b1;
          end else begin
            r_out   <= r_result;
            r_fixed <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: arithmetic reference model, per-cycle compare
// of busy/done/out, directed boundary cases and randomized operations.
module tb_div_unit;
  import rv32ima_pkg::*;

  localparam int NEVER     = 2147483647;
  localparam int NORM_LAT  = 34;

  logic        CLK    = 1'b0;
  logic        nRST   = 1'b0;
  logic        start  = 1'b0;
  logic        flush  = 1'b0;
  div_op_t     div_op = DIV_DIV;
  logic [31:0] in1    = '0;
  logic [31:0] in2    = '0;
  logic        busy;
  logic        done;
  logic [31:0] out;

  div_unit dut (
    .CLK    (CLK),
    .nRST   (nRST),
    .start  (start),
    .div_op (div_op),
    .in1    (in1),
    .in2    (in2),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .out    (out)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int nChecks = 0;
  int nPass   = 0;

  logic        mActive  = 1'b0;
  logic        mSpecial = 1'b0;
  int          mStart   = 0;
  int          mDoneCyc = 0;
  int          mAbortAt = NEVER;
  logic [31:0] mExpOut  = '0;
  logic [31:0] modelOut = '0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic isSignedOp(input div_op_t op);
    return (op == DIV_DIV) || (op == DIV_REM);
  endfunction

  function automatic logic isSpecial(input div_op_t op, input logic [31:0] a, input logic [31:0] b);
    return (b == 0) || (isSignedOp(op) && a == 32'h80000000 && b == 32'hFFFFFFFF);
  endfunction

  // Reference result straight from the RV32M rules using native integer division.
  function automatic logic [31:0] refDiv(input div_op_t op, input logic [31:0] a, input logic [31:0] b);
    logic isRem;
    int   sa;
    int   sb;
    int   r;
    isRem = (op == DIV_REM) || (op == DIV_REMU);
    if (b == 0) return isRem ? a : 32'hFFFFFFFF;
    if (isSignedOp(op)) begin
      if (a == 32'h80000000 && b == 32'hFFFFFFFF) return isRem ? 32'h0 : a;
      sa = a;
      sb = b;
      r  = isRem ? (sa % sb) : (sa / sb);
      return r;
    end
    return isRem ? (a % b) : (a / b);
  endfunction

  // Record a start/flush that the DUT samples at edge e.
  task automatic modelStart(input int e, input div_op_t op, input logic [31:0] a, input logic [31:0] b, input logic fl);
    logic idle;
    idle = !mActive || (mAbortAt <= e - 1) || (mDoneCyc <= e - 2);
    if (fl) begin
      if (mActive && mAbortAt > e) mAbortAt = e;
    end else if (idle) begin
      mActive  = 1'b1;
      mStart   = e;
      mSpecial = isSpecial(op, a, b);
      mDoneCyc = e + (mSpecial ? 0 : NORM_LAT);
      mExpOut  = refDiv(op, a, b);
      mAbortAt = NEVER;
    end
  endtask

  always @(negedge CLK) begin
    logic expBusy;
    logic expDone;
    if (mActive && cyc >= mAbortAt) mActive = 1'b0;
    expBusy = mActive && !mSpecial && cyc >= mStart && cyc < mStart + NORM_LAT;
    expDone = mActive && cyc == mDoneCyc;
    if (expDone) modelOut = mExpOut;
    checkOutput("busy", {31'b0, busy}, {31'b0, expBusy});
    checkOutput("done", {31'b0, done}, {31'b0, expDone});
    checkOutput("out", out, modelOut);
    if (expDone) mActive = 1'b0;
  end

  task automatic applyStimulus(input div_op_t op, input logic [31:0] a, input logic [31:0] b, input logic withFlush);
    @(posedge CLK); #1;
    div_op = op;
    in1    = a;
    in2    = b;
    start  = 1'b1;
    flush  = withFlush;
    modelStart(cyc + 1, op, a, b, withFlush);
    @(posedge CLK); #1;
    start  = 1'b0;
    flush  = 1'b0;
  endtask

  task automatic pulseFlush();
    @(posedge CLK); #1;
    flush = 1'b1;
    if (mActive && mAbortAt > cyc + 1) mAbortAt = cyc + 1;
    @(posedge CLK); #1;
    flush = 1'b0;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while (mActive && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (mActive) begin
      nChecks++;
      $display("[TB] FAIL idle timeout: model still active, expected idle within 100 cycles");
    end
  endtask

  task automatic runDirected(input string name, input div_op_t op, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] expOut, input int expLat, input int expBusy);
    int   lat;
    int   busyCnt;
    logic seen;
    lat     = 0;
    busyCnt = 0;
    seen    = 1'b0;
    applyStimulus(op, a, b, 1'b0);
    while (!seen && lat < 60) begin
      @(negedge CLK);
      lat++;
      if (busy) busyCnt++;
      if (done) seen = 1'b1;
    end
    checkOutput({name, " latency"}, 32'(lat), 32'(expLat));
    checkOutput({name, " busy cycles"}, 32'(busyCnt), 32'(expBusy));
    checkOutput({name, " result"}, out, expOut);
    waitIdle();
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    div_op_t     op;

    checkOutput("model DIVU 100/7", refDiv(DIV_DIVU, 32'd100, 32'd7), 32'h0000000E);
    checkOutput("model REM -7/2", refDiv(DIV_REM, 32'hFFFFFFF9, 32'd2), 32'hFFFFFFFF);
    checkOutput("model DIV -7/2", refDiv(DIV_DIV, 32'hFFFFFFF9, 32'd2), 32'hFFFFFFFD);
    checkOutput("model DIV 1000/-10", refDiv(DIV_DIV, 32'd1000, 32'hFFFFFFF6), 32'hFFFFFF9C);

    repeat (3) @(negedge CLK);
    checkOutput("reset busy", {31'b0, busy}, 32'd0);
    checkOutput("reset done", {31'b0, done}, 32'd0);
    checkOutput("reset out", out, 32'd0);
    @(posedge CLK); #1;
    nRST = 1'b1;

    runDirected("DIVU 100/7", DIV_DIVU, 32'd100, 32'd7, 32'h0000000E, 35, 34);
    runDirected("REMU 100/7", DIV_REMU, 32'd100, 32'd7, 32'h00000002, 35, 34);
    runDirected("DIV -7/2", DIV_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 35, 34);
    runDirected("REM -7/2", DIV_REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 35, 34);
    runDirected("DIVU big/2", DIV_DIVU, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, 35, 34);
    runDirected("DIVU 5/0", DIV_DIVU, 32'd5, 32'd0, 32'hFFFFFFFF, 1, 0);
    runDirected("REMU 5/0", DIV_REMU, 32'd5, 32'd0, 32'h00000005, 1, 0);
    runDirected("DIV min/0", DIV_DIV, 32'h80000000, 32'd0, 32'hFFFFFFFF, 1, 0);
    runDirected("DIV overflow", DIV_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 0);
    runDirected("REM overflow", DIV_REM, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1, 0);

    // Start while busy is ignored; a later flush aborts without touching out.
    applyStimulus(DIV_DIVU, 32'd100, 32'd7, 1'b0);
    repeat (3) @(posedge CLK);
    applyStimulus(DIV_DIVU, 32'd9, 32'd3, 1'b0);
    waitIdle();
    checkOutput("ignored start result", out, 32'd14);
    applyStimulus(DIV_DIVU, 32'd9, 32'd3, 1'b0);
    repeat (7) @(posedge CLK);
    pulseFlush();
    @(negedge CLK);
    checkOutput("busy after flush", {31'b0, busy}, 32'd0);
    repeat (40) @(posedge CLK);
    checkOutput("out after flush", out, 32'd14);

    applyStimulus(DIV_DIVU, 32'd50, 32'd5, 1'b1);
    repeat (5) @(posedge CLK);
    checkOutput("flush beats start", out, 32'd14);

    // Asynchronous reset mid-operation clears outputs immediately.
    applyStimulus(DIV_DIV, 32'd1000, 32'hFFFFFFF6, 1'b0);
    repeat (18) @(posedge CLK);
    #1;
    nRST     = 1'b0;
    mActive  = 1'b0;
    modelOut = '0;
    #1;
    checkOutput("async reset busy", {31'b0, busy}, 32'd0);
    checkOutput("async reset done", {31'b0, done}, 32'd0);
    checkOutput("async reset out", out, 32'd0);
    @(posedge CLK); #1;
    nRST = 1'b1;
    runDirected("DIV 1000/-10", DIV_DIV, 32'd1000, 32'hFFFFFFF6, 32'hFFFFFF9C, 35, 34);

    for (int i = 0; i < 50; i++) begin
      op = div_op_t'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0: begin a = $urandom; b = 32'd0; end
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: begin
          a = $urandom_range(0, 1000);
          b = $urandom_range(1, 20);
          if ($urandom_range(0, 1) == 1) a = -a;
          if ($urandom_range(0, 1) == 1) b = -b;
        end
        default: begin a = $urandom; b = $urandom >> $urandom_range(0, 31); end
      endcase
      applyStimulus(op, a, b, 1'b0);
      case ($urandom_range(0, 5))
        0: begin
          repeat ($urandom_range(1, 30)) @(posedge CLK);
          pulseFlush();
        end
        1: begin
          repeat ($urandom_range(1, 30)) @(posedge CLK);
          applyStimulus(DIV_DIVU, $urandom, $urandom_range(1, 100), 1'b0);
        end
        default: ;
      endcase
      waitIdle();
      repeat ($urandom_range(0, 2)) @(posedge CLK);
    end

    repeat (3) @(posedge CLK);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
